// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: execution-unit result bus and common-data-bus broadcast.
// The master side is the pool of execution units. The slave side is the arbiter.
`timescale 1ns/1ps
interface cdb_arbiter_if #(
  parameter int N_EXU  = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
);
  logic [N_EXU-1:0]        exu_req;
  logic [N_EXU*TAG_W-1:0]  exu_tag;
  logic [N_EXU*DATA_W-1:0] exu_wdata;
  logic [N_EXU-1:0]        exu_rdy;
  logic                    cdb_vld;
  logic [TAG_W-1:0]        cdb_tag;
  logic [DATA_W-1:0]       cdb_data;

  modport master (
    output exu_req, exu_tag, exu_wdata,
    input  exu_rdy, cdb_vld, cdb_tag, cdb_data
  );

  modport slave (
    input  exu_req, exu_tag, exu_wdata,
    output exu_rdy, cdb_vld, cdb_tag, cdb_data
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: picks at most one finished execution-unit result per cycle.
// It broadcasts the winner's tag and data on a registered common data bus one cycle later.
// The default priority is round-robin: the unit after the last winner has the highest priority.
// Build option: define CDB_ARB_FIXED_PRIO_EN to use fixed priority instead.
// With that option, unit 0 is highest and unit N_EXU-1 is lowest, and the rotating pointer is removed.
// The grant (exu_rdy) is a function of exu_req and the pointer only.
// Units can therefore derive their upstream ready from it without forming a loop.
`timescale 1ns/1ps
module cdb_arbiter #(
  parameter int N_EXU  = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  cdb_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(N_EXU);

  logic [PTR_W-1:0]  ptr_s;
  logic [PTR_W:0]    scan_sum_s;
  logic [PTR_W-1:0]  scan_idx_s;
  logic [N_EXU-1:0]  gnt_s;
  logic              gnt_vld_s;
  logic [PTR_W-1:0]  gnt_idx_s;
  logic [TAG_W-1:0]  gnt_tag_s;
  logic [DATA_W-1:0] gnt_data_s;

  logic              cdb_vld_d;
  logic              cdb_vld_q;
  logic [TAG_W-1:0]  cdb_tag_d;
  logic [TAG_W-1:0]  cdb_tag_q;
  logic [DATA_W-1:0] cdb_data_d;
  logic [DATA_W-1:0] cdb_data_q;

`ifdef CDB_ARB_FIXED_PRIO_EN
  assign ptr_s = '0;
`else
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_EXU - 1);

  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] ptr_q;

  // Move the priority pointer just past the winner, wrapping at the last unit.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld_s) begin
      if (gnt_idx_s == LAST_IDX) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx_s + PTR_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_s = ptr_q;
`endif

  // Scan units starting at the pointer and grant the first requester found.
  always_comb begin
    gnt_s      = '0;
    gnt_vld_s  = 1'b0;
    gnt_idx_s  = '0;
    scan_sum_s = '0;
    scan_idx_s = '0;
    for (int k = 0; k < N_EXU; k++) begin
      scan_sum_s = {1'b0, ptr_s} + (PTR_W + 1)'(k);
      if (scan_sum_s >= (PTR_W + 1)'(N_EXU)) begin
        scan_idx_s = PTR_W'(scan_sum_s - (PTR_W + 1)'(N_EXU));
      end else begin
        scan_idx_s = PTR_W'(scan_sum_s);
      end
      if (!gnt_vld_s && bus.exu_req[scan_idx_s]) begin
        gnt_s[scan_idx_s] = 1'b1;
        gnt_vld_s         = 1'b1;
        gnt_idx_s         = scan_idx_s;
      end else begin
        gnt_vld_s = gnt_vld_s;
      end
    end
  end

  // Select the winner's tag and data. The result is all zero when nobody is granted.
  always_comb begin
    gnt_tag_s  = '0;
    gnt_data_s = '0;
    for (int i = 0; i < N_EXU; i++) begin
      if (gnt_s[i]) begin
        gnt_tag_s  = gnt_tag_s  | bus.exu_tag[i*TAG_W +: TAG_W];
        gnt_data_s = gnt_data_s | bus.exu_wdata[i*DATA_W +: DATA_W];
      end else begin
        gnt_tag_s  = gnt_tag_s;
        gnt_data_s = gnt_data_s;
      end
    end
  end

  // Next broadcast value: the winner this cycle, or an all-zero idle bus.
  always_comb begin
    cdb_vld_d  = gnt_vld_s;
    cdb_tag_d  = gnt_tag_s;
    cdb_data_d = gnt_data_s;
  end

  // Broadcast register. A grant in a reset cycle is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cdb_vld_q  <= 1'b0;
      cdb_tag_q  <= '0;
      cdb_data_q <= '0;
    end else begin
      cdb_vld_q  <= cdb_vld_d;
      cdb_tag_q  <= cdb_tag_d;
      cdb_data_q <= cdb_data_d;
    end
  end

  assign bus.exu_rdy  = gnt_s;
  assign bus.cdb_vld  = cdb_vld_q;
  assign bus.cdb_tag  = cdb_tag_q;
  assign bus.cdb_data = cdb_data_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed-vector bench for cdb_arbiter with N_EXU=4, TAG_W=4, DATA_W=32.
// Inputs change 1 ns after the rising edge. Outputs are sampled on the falling edge.
// Build option: CDB_ARB_FIXED_PRIO_EN selects the fixed-priority expectations.
`timescale 1ns/1ps
module tb_cdb_arbiter;
  localparam int N_EXU  = 4;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  cdb_arbiter_if #(.N_EXU(N_EXU), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

  cdb_arbiter #(.N_EXU(N_EXU), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] utag(input int i);
    return 4'(8 + i);
  endfunction

  function automatic logic [31:0] udat(input int i);
    return 32'hA5A5_0000 + 32'(i);
  endfunction

  task automatic load_unit(input int i, input logic [3:0] t, input logic [31:0] d);
    bus.exu_tag[i*TAG_W +: TAG_W]     = t;
    bus.exu_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  // Apply req for one cycle and check the grant and the current broadcast.
  // The call starts 1 ns after a rising edge and returns 1 ns after the next one.
  task automatic cyc(input string name, input logic [3:0] req, input logic [3:0] exp_rdy,
                     input logic exp_vld, input logic [3:0] exp_tag, input logic [31:0] exp_data);
    bus.exu_req = req;
    @(negedge clk);
    check_eq({name, ".rdy"},  32'(bus.exu_rdy),  32'(exp_rdy));
    check_eq({name, ".vld"},  32'(bus.cdb_vld),  32'(exp_vld));
    check_eq({name, ".tag"},  32'(bus.cdb_tag),  32'(exp_tag));
    check_eq({name, ".data"}, bus.cdb_data,      exp_data);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.exu_req   = '0;
    bus.exu_tag   = '0;
    bus.exu_wdata = '0;
    for (int i = 0; i < N_EXU; i++) begin
      load_unit(i, utag(i), udat(i));
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    // Reset is held for two edges with every unit requesting. Nothing is broadcast.
    cyc("rst0", 4'b1111, 4'b0001, 1'b0, 4'h0, 32'h0);
    rst = 1'b0;

`ifdef CDB_ARB_FIXED_PRIO_EN
    // Units 0 and 3 request continuously. Unit 0 wins every cycle.
    for (int k = 0; k < 10; k++) begin
      cyc($sformatf("fp%0d", k), 4'b1001, 4'b0001, (k > 0) ? 1'b1 : 1'b0,
          (k > 0) ? utag(0) : 4'h0, (k > 0) ? udat(0) : 32'h0);
    end
    cyc("fp_end", 4'b0000, 4'b0000, 1'b1, utag(0), udat(0));
    cyc("fp_idle", 4'b0000, 4'b0000, 1'b0, 4'h0, 32'h0);
`else
    // All units request from reset. Grants go 0,1,2,3,0,1, and each broadcast follows one cycle later.
    cyc("rr0", 4'b1111, 4'b0001, 1'b0, 4'h0,    32'h0);
    cyc("rr1", 4'b1111, 4'b0010, 1'b1, utag(0), udat(0));
    cyc("rr2", 4'b1111, 4'b0100, 1'b1, utag(1), udat(1));
    cyc("rr3", 4'b1111, 4'b1000, 1'b1, utag(2), udat(2));
    cyc("rr4", 4'b1111, 4'b0001, 1'b1, utag(3), udat(3));
    cyc("rr5", 4'b1111, 4'b0010, 1'b1, utag(0), udat(0));
    cyc("rr6", 4'b0000, 4'b0000, 1'b1, utag(1), udat(1));
    cyc("rr7", 4'b0000, 4'b0000, 1'b0, 4'h0,    32'h0);
    // ptr is 2. Granting unit 2 moves it to 3. Then unit 3 beats unit 1, and unit 1 wins next.
    cyc("pa0", 4'b0100, 4'b0100, 1'b0, 4'h0,    32'h0);
    cyc("pa1", 4'b1010, 4'b1000, 1'b1, utag(2), udat(2));
    cyc("pa2", 4'b0010, 4'b0010, 1'b1, utag(3), udat(3));
    cyc("pa3", 4'b0000, 4'b0000, 1'b1, utag(1), udat(1));
    // Single request from unit 2 with tag 5 and data 0xDEADBEEF.
    load_unit(2, 4'h5, 32'hDEAD_BEEF);
    cyc("sg0", 4'b0100, 4'b0100, 1'b0, 4'h0,    32'h0);
    cyc("sg1", 4'b0000, 4'b0000, 1'b1, 4'h5,    32'hDEAD_BEEF);
    cyc("sg2", 4'b0000, 4'b0000, 1'b0, 4'h0,    32'h0);
    load_unit(2, utag(2), udat(2));
    // Unit 0 requests on alternate cycles, so cdb_vld toggles. ptr sits at 1 while idle.
    cyc("id0", 4'b0001, 4'b0001, 1'b0, 4'h0,    32'h0);
    cyc("id1", 4'b0000, 4'b0000, 1'b1, utag(0), udat(0));
    cyc("id2", 4'b0001, 4'b0001, 1'b0, 4'h0,    32'h0);
    cyc("id3", 4'b0000, 4'b0000, 1'b1, utag(0), udat(0));
    cyc("id4", 4'b0001, 4'b0001, 1'b0, 4'h0,    32'h0);
    cyc("id5", 4'b0000, 4'b0000, 1'b1, utag(0), udat(0));
    cyc("id6", 4'b1111, 4'b0010, 1'b0, 4'h0,    32'h0);
    cyc("id7", 4'b1111, 4'b0100, 1'b1, utag(1), udat(1));
    // Reset mid-stream. The reset-cycle grant is not broadcast, and ptr returns to 0.
    rst = 1'b1;
    cyc("rs0", 4'b1111, 4'b1000, 1'b1, utag(2), udat(2));
    rst = 1'b0;
    cyc("rs1", 4'b1111, 4'b0001, 1'b0, 4'h0,    32'h0);
    cyc("rs2", 4'b1111, 4'b0010, 1'b1, utag(0), udat(0));
    cyc("rs3", 4'b0000, 4'b0000, 1'b1, utag(1), udat(1));
    cyc("rs4", 4'b0000, 4'b0000, 1'b0, 4'h0,    32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter sitting directly downstream of the execution units (ALU, multiplier, divider, load/store). Each unit holds its finished result as a registered req/tag/wdata triple. The arbiter picks at most one result per cycle with a rotating priority. It broadcasts the winner's tag and data to the reservation stations and ROB on a registered bus one cycle later.

## Interface
Parameters:
- N_EXU, 4, number of execution units on the bus (≥2)
- TAG_W, 4, ROB/physical tag width
- DATA_W, 32, result data width

Ports:
- clk  input  1  clock; everything is on the rising edge
- rst  input  1  reset; synchronous, active-high
- exu_req  input  N_EXU  per-unit result valid; unit i holds it until accepted
- exu_tag  input  N_EXU*TAG_W  packed tags; unit i occupies bits [i*TAG_W +: TAG_W]
- exu_wdata  input  N_EXU*DATA_W  packed results; unit i occupies bits [i*DATA_W +: DATA_W]
- exu_rdy  output  N_EXU  one-hot-or-zero grant; unit i's result is accepted when exu_req[i] && exu_rdy[i]
- cdb_vld  output  1  broadcast valid (registered)
- cdb_tag  output  TAG_W  broadcast tag (registered)
- cdb_data  output  DATA_W  broadcast data (registered)

## Operation
- Priority pointer ptr ($clog2(N_EXU) bits) names the highest-priority unit. Search order is ptr, ptr+1, …, ptr+N_EXU-1, all modulo N_EXU.
- Grant is combinational:
  - exu_rdy[g]=1 only for the first unit g in search order with exu_req[g]=1.
  - All other exu_rdy bits are 0.
  - If no request is pending, exu_rdy=0.
- exu_rdy depends only on exu_req and ptr; it never depends on exu_tag or exu_wdata. This prevents a combinational loop with units whose upstream rdy is derived from their own rdy.
- On a grant:
  - cdb_vld←1
  - cdb_tag←exu_tag[g]
  - cdb_data←exu_wdata[g]
  - ptr←(g+1) mod N_EXU; wrap from N_EXU-1 to 0.
- No grant: cdb_vld←0, cdb_tag←0, cdb_data←0, ptr unchanged.
- The bus has no backpressure; every broadcast is consumed in its cycle.
- Starvation bound: a unit that holds exu_req is granted within N_EXU cycles.
- Simultaneous events: with all units requesting, grants rotate strictly ptr, ptr+1, ….
- A unit may drop and re-raise req the cycle after acceptance. Its new request is arbitrated normally; it now has the lowest priority.
- Arbitration decisions do not depend on data values.

## Timing
- Reset values: cdb_vld=0, cdb_tag=0, cdb_data=0, ptr=0. exu_rdy is combinational, so it is 0 while exu_req=0.
- Reset is asserted mid-operation:
  - Outputs clear on the next edge.
  - A grant in the reset cycle is not broadcast. The unit is considered accepted only if it also sees rdy during that cycle.
  - Units are reset by the same rst, so they drop their results as well.
- Latency: acceptance in cycle T gives the broadcast in cycle T+1, valid for exactly one cycle.
- Throughput: one result per cycle, sustained.
- cdb_vld is never high for two cycles from a single acceptance.

## Configuration
- CDB_ARB_FIXED_PRIO_EN:
  - Defined: priority is fixed, with unit 0 highest and unit N_EXU-1 lowest. ptr is removed (treated as constant 0). The starvation bound does not apply.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset: hold rst 2 cycles with all exu_req=1 → cdb_vld=0, cdb_tag=0, cdb_data=0 throughout. First cycle after reset: exu_rdy=4'b0001.
- Single request: unit 2 raises req with tag=5, data=0xDEADBEEF → exu_rdy=4'b0100 that cycle. Next cycle: cdb_vld=1, cdb_tag=5, cdb_data=0xDEADBEEF. Following cycle: cdb_vld=0 (unit dropped req).
- Round-robin with wrap: all 4 units request continuously from reset → grants 0,1,2,3,0,1 on consecutive cycles, with matching tags broadcast one cycle later each.
- Priority after grant: ptr=3, units 1 and 3 request → unit 3 granted, ptr→0. Next cycle unit 1 granted, ptr→2.
- Idle gaps: requests on alternate cycles from unit 0 → cdb_vld toggles 0/1, ptr toggles 1 (after grant) and stays 1 while idle.
- Fixed-priority build (CDB_ARB_FIXED_PRIO_EN defined): units 0 and 3 request continuously → unit 0 granted every cycle, exu_rdy[3]=0 for 10 cycles.
